silly_sweep_ctrl: RTL and testbench
===================================

// Module: silly_sweep_ctrl
// PURPOSE
//  Self-test sequencer for the 3-input sillyfunction block.
//  On a start pulse it drives all 8 {a,b,c} combinations into the DUT in order 000..111.
//  It waits a programmable settle time per vector, samples y, and compares y to an expected truth table.
//  It reports a pass/fail summary with a done pulse.
//  It sits between a board-level start button/host strobe and one sillyfunction instance.
// PARAMETERS
//  SETTLE    2      cycles a,b,c are held before y is sampled; legal range 1..15
//  EXPECTED  8'h31  golden truth table; bit i = expected y for {a,b,c}==i
//                   (y = ~b&~c | a&~b)
// PORTS
//  clk         in   1  single clock; all state changes on posedge
//  reset       in   1  synchronous, active-high
//  start       in   1  request a sweep; accepted only in IDLE
//  a,b,c       out  1  DUT inputs; {a,b,c} = current vector index
//  y           in   1  DUT output
//  busy        out  1  high from the cycle after start is accepted until the DONE cycle inclusive
//  done        out  1  one-cycle pulse when the sweep completes
//  pass        out  1  1 if all 8 vectors matched; valid from done, held until next accepted start
//  fail_count  out  4  number of mismatching vectors (0..8)
//  first_fail  out  3  index of the lowest mismatching vector; 0 when fail_count==0
//  result      out  8  captured y per vector; bit i = y sampled for index i
// BEHAVIOUR
//  Reset (sync, clk edge with reset=1):
//   state=IDLE; idx=0; settle cnt=0.
//   All outputs 0: {a,b,c}=000, busy, done, pass, fail_count, first_fail, result.
//   Reset overrides start and any in-progress sweep; no done pulse is produced.
//  FSM states: IDLE -> WAIT -> SAMPLE -> (WAIT | DONE) -> IDLE
//   IDLE:
//    start=1 -> WAIT, idx=0, cnt=0, result=0, fail_count=0, first_fail=0, pass=0.
//    Otherwise stay in IDLE; pass, fail_count, first_fail and result hold their values.
//   WAIT:
//    cnt increments each cycle; when cnt==SETTLE-1 -> SAMPLE.
//    WAIT lasts exactly SETTLE cycles.
//   SAMPLE (1 cycle), at the exiting edge:
//    result[idx] <= y.
//    If y != EXPECTED[idx]: fail_count++; if this is the first mismatch, first_fail <= idx.
//    If idx==7 -> DONE; else idx++, cnt=0 -> WAIT.
//   DONE (1 cycle):
//    done=1; pass=(fail_count==0) is registered so it is visible together with done.
//    Next state is IDLE.
//  {a,b,c} is driven from registered idx. It is stable through WAIT and SAMPLE.
//  It is held at 111 through DONE and IDLE until the next start.
//  Timing:
//   Each vector takes SETTLE+1 cycles.
//   Start accepted at edge 0 -> done high in cycle 8*(SETTLE+1)+1.
//  Handshake:
//   start is level-sampled and ignored while busy.
//   start held high re-triggers on the first IDLE cycle after DONE, so sweeps run back-to-back.
//  Width and saturation:
//   fail_count cannot exceed 8, so no saturation is needed.
//   idx does not wrap inside a sweep; 7 is terminal.
// TESTING
//  1. Correct DUT, SETTLE=2, one-cycle start:
//     -> done in cycle 25, pass=1, result=8'h31, fail_count=0, first_fail=0.
//  2. y stuck at 0:
//     -> pass=0, result=8'h00, fail_count=3, first_fail=0.
//  3. y = ~correct:
//     -> result=8'hCE, fail_count=8, first_fail=0, pass=0.
//  4. start pulsed while busy, at idx=3:
//     -> ignored; exactly one done pulse, still in cycle 25.
//  5. reset asserted while idx=4:
//     -> next cycle all outputs 0, {a,b,c}=000, IDLE.
//     -> a following start completes a full sweep with pass=1.
//  6. start held high continuously:
//     -> done pulses every 26 cycles.
//     -> busy is low for exactly one cycle between sweeps.
//     -> {a,b,c} restarts at 000.

Source files
------------

// File: rtl/silly_sweep_ctrl.sv
// Self-test sequencer: sweeps {a,b,c} through 000..111, samples y after a settle delay,
// and compares against a golden truth table, reporting a pass/fail summary with a done pulse.
module silly_sweep_ctrl #(
  parameter int unsigned SETTLE   = 2,
  parameter logic [7:0]  EXPECTED = 8'h31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [2:0] first_fail,
  output logic [7:0] result
);

  typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] fail_count_q, fail_count_d;
  logic [2:0] first_fail_q, first_fail_d;
  logic [7:0] result_q, result_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    fail_count_d = fail_count_q;
    first_fail_d = first_fail_q;
    result_d     = result_q;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (start) begin
          state_d      = StWait;
          idx_d        = 3'd0;
          cnt_d        = 4'd0;
          busy_d       = 1'b1;
          pass_d       = 1'b0;
          fail_count_d = 4'd0;
          first_fail_d = 3'd0;
          result_d     = 8'd0;
        end
      end
      StWait: begin
        if (cnt_q == SettleLast) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StSample: begin
        result_d[idx_q] = y;
        if (y != EXPECTED[idx_q]) begin
          fail_count_d = fail_count_q + 4'd1;
          // Only the lowest mismatching index is kept; vectors arrive in ascending order.
          if (fail_count_q == 4'd0) begin
            first_fail_d = idx_q;
          end
        end
        if (idx_q == 3'd7) begin
          state_d = StDone;
          done_d  = 1'b1;
          pass_d  = (fail_count_d == 4'd0);
        end else begin
          state_d = StWait;
          idx_d   = idx_q + 3'd1;
          cnt_d   = 4'd0;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      idx_q        <= 3'd0;
      cnt_q        <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_count_q <= 4'd0;
      first_fail_q <= 3'd0;
      result_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      fail_count_q <= fail_count_d;
      first_fail_q <= first_fail_d;
      result_q     <= result_d;
    end
  end

  assign {a, b, c}  = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_count_q;
  assign first_fail = first_fail_q;
  assign result     = result_q;

endmodule

// File: tb/tb_silly_sweep_ctrl.sv
// Bench for silly_sweep_ctrl: table-driven sweeps, randomized y tables against a truth-table
// model, plus hand-written sequences for busy re-start, mid-sweep reset and held start.
module tb_silly_sweep_ctrl;

  localparam int unsigned SETTLE   = 2;
  localparam logic [7:0]  EXPECTED = 8'h31;
  localparam int          Per      = SETTLE + 1;
  localparam int          Lat      = 8 * Per;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       a, b, c, y;
  logic       busy, done, pass;
  logic [3:0] fail_count;
  logic [2:0] first_fail;
  logic [7:0] result;
  logic [7:0] y_map;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] ymap;
    logic [7:0] res;
    int         fc;
    int         ff;
    logic       ps;
  } vec_t;

  vec_t tbl[7];

  silly_sweep_ctrl #(
    .SETTLE  (SETTLE),
    .EXPECTED(EXPECTED)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .c         (c),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_count(fail_count),
    .first_fail(first_fail),
    .result    (result)
  );

  // The device under sweep: y is a lookup on the applied vector.
  assign y = y_map[{a, b, c}];

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: y sampled per vector, mismatches counted against the golden table.
  function automatic void model(input logic [7:0] m, output logic [7:0] r, output int fc,
                                output int ff, output logic p);
    r  = m;
    fc = 0;
    ff = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i] !== EXPECTED[i]) begin
        if (fc == 0) ff = i;
        fc++;
      end
    end
    p = (fc == 0);
  endfunction

  // Starts a sweep from IDLE (called #1 after a posedge) and checks it cycle by cycle.
  task automatic run_sweep(input logic [7:0] map, input logic [7:0] er, input int efc,
                           input int eff, input logic ep, input int pulse_n, input string tag);
    int done_n;
    int done_cnt;
    int seq_err;
    done_n   = -1;
    done_cnt = 0;
    seq_err  = 0;
    y_map = map;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 0; n <= Lat + 1; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (n == pulse_n) start = 1'b1;
      else if (n == pulse_n + 1) start = 1'b0;
      if (done) begin
        done_cnt++;
        done_n = n;
      end
      if (n < Lat) begin
        if ({a, b, c} !== 3'(n / Per) || busy !== 1'b1 || done !== 1'b0) seq_err++;
      end
      if (n == Lat) begin
        check({tag, " result"}, result, er);
        check({tag, " fail_count"}, fail_count, efc);
        check({tag, " first_fail"}, first_fail, eff);
        check({tag, " pass"}, pass, ep);
        check({tag, " busy_in_done"}, {busy, a, b, c}, 4'b1111);
      end
      if (n == Lat + 1) check({tag, " idle_after"}, {busy, done, a, b, c}, 5'b00111);
    end
    start = 1'b0;
    check({tag, " vector_sequence_errs"}, seq_err, 0);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " done_cycle"}, done_n, Lat);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check({tag, " summary_held"}, {pass, fail_count, first_fail, result},
          {ep, 4'(efc), 3'(eff), er});
  endtask

  initial begin
    logic [7:0] mr;
    int         mfc;
    int         mff;
    logic       mp;
    int         dn[$];
    int         low[$];
    int         stray;

    tbl[0] = '{8'h31, 8'h31, 0, 0, 1'b1};
    tbl[1] = '{8'h00, 8'h00, 3, 0, 1'b0};
    tbl[2] = '{8'hCE, 8'hCE, 8, 0, 1'b0};
    tbl[3] = '{8'hFF, 8'hFF, 5, 1, 1'b0};
    tbl[4] = '{8'h30, 8'h30, 1, 0, 1'b0};
    tbl[5] = '{8'h11, 8'h11, 1, 5, 1'b0};
    tbl[6] = '{8'hB1, 8'hB1, 1, 7, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    y_map = 8'h31;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {a, b, c, busy, done, pass, fail_count, first_fail, result}, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_sweep(tbl[i].ymap, tbl[i].res, tbl[i].fc, tbl[i].ff, tbl[i].ps, -1,
                $sformatf("vec%0d", i));
    end

    // start pulsed while the sweep is on vector 3
    run_sweep(8'h31, 8'h31, 0, 0, 1'b1, 3 * Per, "busy_start");

    for (int i = 0; i < 6; i++) begin
      logic [7:0] m;
      m = 8'($urandom);
      model(m, mr, mfc, mff, mp);
      run_sweep(m, mr, mfc, mff, mp, -1, $sformatf("rand%0d", i));
    end

    // Reset in the middle of vector 4
    y_map = 8'h31;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4 * Per) begin
      @(posedge clk);
      #1;
    end
    check("mid_idx_before_reset", {a, b, c}, 3'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("mid_reset_state", {a, b, c, busy, done, pass, fail_count, first_fail, result}, 0);
    stray = 0;
    repeat (Lat + 5) begin
      @(posedge clk);
      #1;
      if (done || busy) stray++;
    end
    check("no_done_after_reset", stray, 0);
    run_sweep(8'h31, 8'h31, 0, 0, 1'b1, -1, "after_reset");

    // start held high: back-to-back sweeps
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n <= 80; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (done) dn.push_back(n);
      if (!busy) low.push_back(n);
      if (n == Lat + 1) check("held_idle_abc", {a, b, c}, 3'd7);
      if (n == Lat + 2) check("held_restart_abc", {busy, a, b, c}, 4'b1000);
    end
    start = 1'b0;
    check("held_done_count", dn.size(), 3);
    if (dn.size() == 3) begin
      check("held_first_done", dn[0], Lat);
      check("held_period1", dn[1] - dn[0], Lat + 2);
      check("held_period2", dn[2] - dn[1], Lat + 2);
    end
    check("held_busy_low_count", low.size(), 3);
    if (low.size() == 3) begin
      for (int i = 0; i < 3; i++) check($sformatf("held_busy_low%0d", i), low[i], 25 + 26 * i);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
